// File: rtl/rate_monitor_if.sv
// rate_monitor_if: sample stream, configuration and status bundle for rate_monitor.
// The master drives the samples and configuration. The slave (the monitor) drives the status.
interface rate_monitor_if #(
    parameter int CNT_W = 8
);
    logic             valid;
    logic [5:0]       d_in;
    logic [5:0]       target;
    logic [2:0]       step_size;
    logic             clr;
    logic             viol;
    logic [CNT_W-1:0] viol_cnt;
    logic             settled;
    logic [1:0]       state;

    modport master (
        output valid, d_in, target, step_size, clr,
        input  viol, viol_cnt, settled, state
    );

    modport slave (
        input  valid, d_in, target, step_size, clr,
        output viol, viol_cnt, settled, state
    );
endinterface

// File: rtl/rate_monitor.sv
// rate_monitor: checks that a slewing 6-bit stream never moves more than step_size
// per valid sample, and reports when the stream has settled on target.
// Optional build macro RATE_MONITOR_STICKY_FAULT_EN makes a violation latch FAULT
// until clr or reset. Without the macro, FAULT is never entered.
//
// state   | meaning
// IDLE    | no sample seen since reset; the next sample only loads prev
// TRACK   | checking step size and counting consecutive on-target samples
// SETTLED | stream has sat on target for SETTLE_CYCLES samples
// FAULT   | sticky violation latched; counting continues, no settle tracking
module rate_monitor #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic           clk,
    input  logic           rst,
    rate_monitor_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        SETTLED = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_TGT = 4'(SETTLE_CYCLES);

`ifdef RATE_MONITOR_STICKY_FAULT_EN
    localparam state_t VIOL_STATE = FAULT;
`else
    localparam state_t VIOL_STATE = TRACK;
`endif

    state_t           state_q, state_d;
    logic [5:0]       prev_q, prev_d;
    logic [3:0]       settle_q, settle_d;
    logic             viol_q, viol_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             settled_q;
    logic [5:0]       delta;
    logic             is_viol;

    // Absolute difference without wrap: the larger value minus the smaller.
    always_comb begin
        delta = (bus.d_in >= prev_q) ? (bus.d_in - prev_q) : (prev_q - bus.d_in);
    end

    // Next-state, counters and pulse for each cycle.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        settle_d = settle_q;
        viol_d   = 1'b0;
        vcnt_d   = vcnt_q;
        is_viol  = bus.valid && (state_q != IDLE) && (delta > {3'b000, bus.step_size});

        if (bus.valid) begin
            prev_d = bus.d_in;
            if (is_viol) begin
                viol_d   = 1'b1;
                vcnt_d   = (vcnt_q == '1) ? vcnt_q : vcnt_q + 1'b1;
                settle_d = 4'd0;
            end
            case (state_q)
                IDLE: begin
                    state_d  = TRACK;
                    settle_d = 4'd0;
                end
                TRACK: begin
                    if (is_viol) begin
                        state_d = VIOL_STATE;
                    end else if (bus.d_in == bus.target) begin
                        settle_d = settle_q + 4'd1;
                        if (settle_q + 4'd1 == SETTLE_TGT) begin
                            state_d = SETTLED;
                        end
                    end else begin
                        settle_d = 4'd0;
                    end
                end
                SETTLED: begin
                    if (is_viol) begin
                        state_d = VIOL_STATE;
                    end else if (bus.d_in != bus.target) begin
                        state_d  = TRACK;
                        settle_d = 4'd0;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        // clr beats a simultaneous violation: the count clears and FAULT is not entered.
        if (bus.clr) begin
            vcnt_d   = '0;
            settle_d = 4'd0;
            if (state_d == FAULT) begin
                state_d = TRACK;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            prev_q    <= 6'd0;
            settle_q  <= 4'd0;
            viol_q    <= 1'b0;
            vcnt_q    <= '0;
            settled_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            prev_q    <= prev_d;
            settle_q  <= settle_d;
            viol_q    <= viol_d;
            vcnt_q    <= vcnt_d;
            settled_q <= (state_d == SETTLED);
        end
    end

    assign bus.viol     = viol_q;
    assign bus.viol_cnt = vcnt_q;
    assign bus.settled  = settled_q;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_rate_monitor.sv
// tb_rate_monitor: table-driven directed checks of rate_monitor. A second instance
// with a 2-bit counter covers saturation.
module tb_rate_monitor;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

`ifdef RATE_MONITOR_STICKY_FAULT_EN
    localparam logic [1:0] S = 2'd3;
`else
    localparam logic [1:0] S = 2'd1;
`endif

    rate_monitor_if #(.CNT_W(8)) bus  ();
    rate_monitor_if #(.CNT_W(2)) bus2 ();

    rate_monitor #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    rate_monitor #(.SETTLE_CYCLES(4), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       r;
        logic       v;
        logic [5:0] d;
        logic [5:0] t;
        logic [2:0] s;
        logic       c;
        logic       ev;
        logic [7:0] ec;
        logic       es;
        logic [1:0] est;
    } vec_t;

    vec_t vecs [27];

    function automatic vec_t mk(logic r, logic v, logic [5:0] d, logic [5:0] t, logic [2:0] s,
                                logic c, logic ev, logic [7:0] ec, logic es, logic [1:0] est);
        vec_t x;
        x.r = r; x.v = v; x.d = d; x.t = t; x.s = s; x.c = c;
        x.ev = ev; x.ec = ec; x.es = es; x.est = est;
        return x;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        bus.valid = 1'b0; bus.d_in = '0; bus.target = '0; bus.step_size = '0; bus.clr = 1'b0;
        bus2.valid = 1'b0; bus2.d_in = '0; bus2.target = '0; bus2.step_size = '0; bus2.clr = 1'b0;
        #1;
        check("rst_state", int'(bus.state), 0);
        check("rst_cnt", int'(bus.viol_cnt), 0);
        check("rst_settled", int'(bus.settled), 0);
        check("rst_viol", int'(bus.viol), 0);

        vecs[0]  = mk(1,1, 0,30,7,0, 0,0,0,1);
        vecs[1]  = mk(0,1, 7,30,7,0, 0,0,0,1);
        vecs[2]  = mk(0,1,14,30,7,0, 0,0,0,1);
        vecs[3]  = mk(0,1,21,30,7,0, 0,0,0,1);
        vecs[4]  = mk(0,1,28,30,7,0, 0,0,0,1);
        vecs[5]  = mk(0,1,30,30,7,0, 0,0,0,1);
        vecs[6]  = mk(0,1,30,30,7,0, 0,0,0,1);
        vecs[7]  = mk(0,1,30,30,7,0, 0,0,0,1);
        vecs[8]  = mk(0,1,30,30,7,0, 0,0,1,2);
        vecs[9]  = mk(0,0, 5,30,7,0, 0,0,1,2);
        vecs[10] = mk(0,1,23,15,7,0, 0,0,0,1);
        vecs[11] = mk(0,1,15,15,7,0, 1,1,0,S);
        vecs[12] = mk(0,0,15,15,7,0, 0,1,0,S);
        vecs[13] = mk(0,0,15,15,7,1, 0,0,0,1);
        vecs[14] = mk(1,1,10,15,0,0, 0,0,0,1);
        vecs[15] = mk(0,1,10,15,0,0, 0,0,0,1);
        vecs[16] = mk(0,1,11,15,0,0, 1,1,0,S);
        vecs[17] = mk(0,0,11,15,0,0, 0,1,0,S);
        vecs[18] = mk(0,1,11,15,0,0, 0,1,0,S);
        vecs[19] = mk(0,0,11,15,0,1, 0,0,0,1);
        vecs[20] = mk(1,1, 2,15,6,0, 0,0,0,1);
        vecs[21] = mk(0,1,63,15,6,0, 1,1,0,S);
        vecs[22] = mk(0,1,63,15,6,0, 0,1,0,S);
        vecs[23] = mk(0,1, 0,15,6,0, 1,2,0,S);
        vecs[24] = mk(0,1, 6,15,6,0, 0,2,0,S);
        vecs[25] = mk(0,1,13,15,6,0, 1,3,0,S);
        vecs[26] = mk(0,1, 0,15,6,1, 1,0,0,1);

        for (int i = 0; i < 27; i++) begin
            @(negedge clk);
            if (vecs[i].r) pulse_reset();
            bus.valid = vecs[i].v;
            bus.d_in = vecs[i].d;
            bus.target = vecs[i].t;
            bus.step_size = vecs[i].s;
            bus.clr = vecs[i].c;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_viol", i), int'(bus.viol), int'(vecs[i].ev));
            check($sformatf("v%0d_cnt", i), int'(bus.viol_cnt), int'(vecs[i].ec));
            check($sformatf("v%0d_settled", i), int'(bus.settled), int'(vecs[i].es));
            check($sformatf("v%0d_state", i), int'(bus.state), int'(vecs[i].est));
        end

        // Asynchronous reset in the middle of a cycle while TRACK holds a nonzero count.
        @(negedge clk);
        pulse_reset();
        bus.clr = 1'b0; bus.valid = 1'b1; bus.step_size = 3'd7; bus.target = 6'd50; bus.d_in = 6'd20;
        @(negedge clk);
        bus.d_in = 6'd40;
        @(negedge clk);
        bus.valid = 1'b0;
        check("pre_rst_cnt", int'(bus.viol_cnt), 1);
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_state", int'(bus.state), 0);
        check("async_rst_cnt", int'(bus.viol_cnt), 0);
        check("async_rst_viol", int'(bus.viol), 0);
        check("async_rst_settled", int'(bus.settled), 0);
        @(negedge clk);
        rst = 1'b1;
        bus.valid = 1'b1; bus.d_in = 6'd50;
        @(posedge clk);
        #1;
        check("post_rst_viol", int'(bus.viol), 0);
        check("post_rst_state", int'(bus.state), 1);
        @(negedge clk);
        bus.valid = 1'b0;

        // Saturation of the 2-bit counter, then clr together with a violation.
        @(negedge clk);
        pulse_reset();
        bus2.step_size = 3'd0; bus2.target = 6'd0; bus2.clr = 1'b0;
        bus2.valid = 1'b1; bus2.d_in = 6'd0;
        @(posedge clk);
        #1;
        check("sat_first_viol", int'(bus2.viol), 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            bus2.d_in = 6'(k % 2);
            @(posedge clk);
            #1;
            check($sformatf("sat_viol%0d", k), int'(bus2.viol), 1);
            check($sformatf("sat_cnt%0d", k), int'(bus2.viol_cnt), (k < 3) ? k : 3);
        end
        @(negedge clk);
        bus2.valid = 1'b0;
        @(posedge clk);
        #1;
        check("sat_hold_cnt", int'(bus2.viol_cnt), 3);
        check("sat_hold_viol", int'(bus2.viol), 0);
        @(negedge clk);
        bus2.valid = 1'b1; bus2.d_in = 6'd0; bus2.clr = 1'b1;
        @(posedge clk);
        #1;
        check("clr_viol_pulse", int'(bus2.viol), 1);
        check("clr_viol_cnt", int'(bus2.viol_cnt), 0);
        check("clr_viol_state", int'(bus2.state), 1);
        @(negedge clk);
        bus2.valid = 1'b0; bus2.clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
